// File: rtl/com_uart_tx_if.sv
// Byte-capture and serial-status bundle between the interpreter side and the UART transmitter.
// The master drives the byte strobe and data; the slave (the transmitter) reports line and FIFO status.
interface com_uart_tx_if #(
  parameter int FIFO_DEPTH = 16
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          byte_strobe;
  logic [7:0]    byte_in;
  logic          tx;
  logic          busy;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output byte_strobe, byte_in,
    input  tx, busy, fifo_full, fifo_count, overflow
  );

  modport slave (
    input  byte_strobe, byte_in,
    output tx, busy, fifo_full, fifo_count, overflow
  );
endinterface

// File: rtl/com_uart_tx.sv
// UART 8N1 transmitter fed by a byte FIFO; each rising edge of the interpreter strobe queues one byte.
// Frames are sent LSB first, back-to-back while bytes are queued; a push into a full FIFO sets a sticky overflow.
module com_uart_tx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic         clk,
  input  logic         reset,
  com_uart_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          strb_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          push_s, push_ok_s, pop_s, empty_s, baud_last_s;
  logic [7:0]    head_s;

  assign push_s      = bus.byte_strobe & ~strb_q;
  assign empty_s     = (count_q == '0);
  assign baud_last_s = (baud_cnt_q == BAUD_LAST);
  assign head_s      = mem_q[rd_ptr_q];

  // Frame sequencer: pops the FIFO head whenever the line is free and a byte is waiting.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    pop_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (!empty_s) begin
          pop_s     = 1'b1;
          shift_d   = head_s;
          bit_cnt_d = 3'd0;
          state_d   = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_last_s) begin
          baud_cnt_d = '0;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_last_s) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (baud_last_s) begin
          baud_cnt_d = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (!empty_s) begin
            pop_s     = 1'b1;
            shift_d   = head_s;
            bit_cnt_d = 3'd0;
            state_d   = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  // Line level and busy flag, registered from the current state so they stay aligned.
  always_comb begin
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != ST_IDLE) | (count_q != '0);
  end

  // FIFO occupancy: a push into a full FIFO is still taken when the head leaves in the same cycle.
  always_comb begin
    push_ok_s  = push_s & ((count_q != CNT_FULL) | pop_s);
    overflow_d = overflow_q | (push_s & ~push_ok_s);
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      baud_cnt_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      strb_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      strb_q     <= bus.byte_strobe;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= bus.byte_in;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = count_q;
  assign bus.fifo_full  = (count_q == CNT_FULL);
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_com_uart_tx.sv
// Directed bench for com_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Sample k of a run is taken at the falling edge after edge N+k-1, where edge N precedes the first drive.
module tb_com_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int MAXS  = 400;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  com_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  com_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic       strb_s  [1:MAXS];
  logic [7:0] dat_s   [1:MAXS];
  logic       exp_tx  [1:MAXS];
  logic       tx_log  [1:MAXS];
  logic       busy_log[1:MAXS];
  logic       ovf_log [1:MAXS];
  logic       full_log[1:MAXS];
  logic [2:0] cnt_log [1:MAXS];

  task automatic clear_plan();
    for (int k = 1; k <= MAXS; k++) begin
      strb_s[k] = 1'b0;
      dat_s[k]  = 8'h00;
      exp_tx[k] = 1'b1;
    end
  endtask

  task automatic plan_strobe(input int k, input logic [7:0] b, input int hold);
    for (int h = 0; h < hold; h++) begin
      strb_s[k+h] = 1'b1;
      dat_s[k+h]  = b;
    end
  endtask

  // Expected line: start bit at sample s for 4 samples, data LSB first, then stop.
  task automatic plan_frame(input int s, input logic [7:0] b);
    for (int c = 0; c < CPB; c++) begin
      exp_tx[s+c] = 1'b0;
      exp_tx[s+9*CPB+c] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        exp_tx[s+CPB+CPB*i+c] = b[i];
      end
    end
  endtask

  task automatic run(input int n);
    @(posedge clk); #1;
    for (int k = 1; k <= n; k++) begin
      bus.byte_strobe = strb_s[k];
      bus.byte_in     = dat_s[k];
      @(negedge clk);
      tx_log[k]   = bus.tx;
      busy_log[k] = bus.busy;
      ovf_log[k]  = bus.overflow;
      full_log[k] = bus.fifo_full;
      cnt_log[k]  = bus.fifo_count;
      @(posedge clk); #1;
    end
    bus.byte_strobe = 1'b0;
  endtask

  task automatic wave_diff(input int n, output int bad, output int first);
    bad = 0;
    first = 0;
    for (int k = 1; k <= n; k++) begin
      if (tx_log[k] !== exp_tx[k]) begin
        if (bad == 0) first = k;
        bad++;
      end
    end
  endtask

  task automatic test_reset();
    bus.byte_strobe = 1'b0;
    bus.byte_in     = 8'h00;
    #1 reset = 1'b0;
    #2;
    n_checks++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    n_checks++; if (bus.fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.fifo_full); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_single_frame();
    int bad, first;
    clear_plan();
    plan_strobe(1, 8'h55, 1);
    plan_frame(4, 8'h55);
    run(50);
    wave_diff(50, bad, first);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL single_wave: %0d samples wrong, first at %0d (got %b want %b)", bad, first, tx_log[first], exp_tx[first]); end
    n_checks++; if (cnt_log[2] !== 3'd1) begin n_fail++; $display("FAIL single_count_written: got %0d want 1", cnt_log[2]); end
    n_checks++; if (cnt_log[3] !== 3'd0) begin n_fail++; $display("FAIL single_count_popped: got %0d want 0", cnt_log[3]); end
    n_checks++; if (busy_log[43] !== 1'b1) begin n_fail++; $display("FAIL single_busy_stop: got %b want 1", busy_log[43]); end
    n_checks++; if (busy_log[44] !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy_log[44]); end
  endtask

  task automatic test_held_strobe();
    int bad, first, peak;
    clear_plan();
    plan_strobe(1, 8'hA3, 10);
    plan_frame(4, 8'hA3);
    run(60);
    wave_diff(60, bad, first);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL held_wave: %0d samples wrong, first at %0d (got %b want %b)", bad, first, tx_log[first], exp_tx[first]); end
    peak = 0;
    for (int k = 1; k <= 60; k++) if (int'(cnt_log[k]) > peak) peak = int'(cnt_log[k]);
    n_checks++; if (peak !== 1) begin n_fail++; $display("FAIL held_count_peak: got %0d want 1", peak); end
  endtask

  task automatic test_overflow();
    int bad, first;
    clear_plan();
    for (int j = 0; j < 6; j++) plan_strobe(1 + 2*j, 8'(j + 1), 1);
    for (int j = 0; j < 5; j++) plan_frame(4 + 40*j, 8'(j + 1));
    run(210);
    wave_diff(210, bad, first);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ovf_wave: %0d samples wrong, first at %0d (got %b want %b)", bad, first, tx_log[first], exp_tx[first]); end
    n_checks++; if (cnt_log[10] !== 3'd4) begin n_fail++; $display("FAIL ovf_count_full: got %0d want 4", cnt_log[10]); end
    n_checks++; if (full_log[10] !== 1'b1) begin n_fail++; $display("FAIL ovf_full_flag: got %b want 1", full_log[10]); end
    n_checks++; if (ovf_log[11] !== 1'b0) begin n_fail++; $display("FAIL ovf_before_drop: got %b want 0", ovf_log[11]); end
    n_checks++; if (ovf_log[12] !== 1'b1) begin n_fail++; $display("FAIL ovf_after_drop: got %b want 1", ovf_log[12]); end
    n_checks++; if (ovf_log[210] !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf_log[210]); end
    n_checks++; if (busy_log[203] !== 1'b1) begin n_fail++; $display("FAIL ovf_busy_last_stop: got %b want 1", busy_log[203]); end
    n_checks++; if (busy_log[204] !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_end: got %b want 0", busy_log[204]); end
  endtask

  task automatic test_reset_mid_frame();
    clear_plan();
    for (int j = 0; j < 6; j++) plan_strobe(1 + 2*j, 8'h00, 1);
    run(20);
    n_checks++; if (tx_log[20] !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_tx: got %b want 0", tx_log[20]); end
    n_checks++; if (cnt_log[20] !== 3'd4) begin n_fail++; $display("FAIL midrst_pre_count: got %0d want 4", cnt_log[20]); end
    n_checks++; if (ovf_log[20] !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_ovf: got %b want 1", ovf_log[20]); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b want 1", bus.tx); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", bus.fifo_count); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %b want 0", bus.overflow); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin n_fail++; $display("FAIL midrst_after_release: busy=%b tx=%b want busy=0 tx=1", bus.busy, bus.tx); end
  endtask

  task automatic test_push_pop_same_cycle();
    int bad, first;
    clear_plan();
    for (int j = 0; j < 5; j++) plan_strobe(1 + 2*j, 8'(8'h11 + j), 1);
    plan_strobe(42, 8'h16, 1);
    for (int j = 0; j < 6; j++) plan_frame(4 + 40*j, 8'(8'h11 + j));
    run(250);
    wave_diff(250, bad, first);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL pushpop_wave: %0d samples wrong, first at %0d (got %b want %b)", bad, first, tx_log[first], exp_tx[first]); end
    n_checks++; if (cnt_log[41] !== 3'd4) begin n_fail++; $display("FAIL pushpop_count_before: got %0d want 4", cnt_log[41]); end
    n_checks++; if (cnt_log[43] !== 3'd4) begin n_fail++; $display("FAIL pushpop_count_after: got %0d want 4", cnt_log[43]); end
    n_checks++; if (full_log[43] !== 1'b1) begin n_fail++; $display("FAIL pushpop_full: got %b want 1", full_log[43]); end
    n_checks++; if (ovf_log[43] !== 1'b0) begin n_fail++; $display("FAIL pushpop_ovf: got %b want 0", ovf_log[43]); end
    n_checks++; if (busy_log[244] !== 1'b0) begin n_fail++; $display("FAIL pushpop_busy_end: got %b want 0", busy_log[244]); end
  endtask

  task automatic test_pointer_wrap();
    int bad, first;
    clear_plan();
    for (int j = 0; j < 5; j++) plan_strobe(1 + 2*j, 8'(8'h21 + j), 1);
    for (int j = 0; j < 5; j++) plan_frame(4 + 40*j, 8'(8'h21 + j));
    plan_strobe(220, 8'hFF, 1);
    plan_strobe(222, 8'h00, 1);
    plan_frame(223, 8'hFF);
    plan_frame(263, 8'h00);
    run(310);
    wave_diff(310, bad, first);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL wrap_wave: %0d samples wrong, first at %0d (got %b want %b)", bad, first, tx_log[first], exp_tx[first]); end
    n_checks++; if (busy_log[210] !== 1'b0) begin n_fail++; $display("FAIL wrap_drained_idle: got %b want 0", busy_log[210]); end
    n_checks++; if (busy_log[302] !== 1'b1) begin n_fail++; $display("FAIL wrap_busy_last_stop: got %b want 1", busy_log[302]); end
    n_checks++; if (busy_log[303] !== 1'b0) begin n_fail++; $display("FAIL wrap_busy_end: got %b want 0", busy_log[303]); end
    n_checks++; if (cnt_log[310] !== 3'd0) begin n_fail++; $display("FAIL wrap_count_end: got %0d want 0", cnt_log[310]); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_held_strobe();
    test_overflow();
    test_reset_mid_frame();
    test_push_pop_same_cycle();
    test_pointer_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
